// File: rtl/bf_gen_pipe.sv
// Modular butterfly pipeline: NTT (Cooley-Tukey), INTT (Gentleman-Sande with halving) and MSM add/mul,
// all mod M, with a global-stall valid/ready handshake and a tag carried alongside each op.
module bf_gen_pipe #(
  parameter int unsigned  W       = 64,
  parameter logic [W-1:0] M       = 64'hFFFFFFFF00000001,
  parameter logic [W-1:0] M_HALF  = 64'h7FFFFFFF80000001,
  parameter int unsigned  MUL_LAT = 4,
  parameter int unsigned  TAG_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 a_i,
  input  logic [W-1:0]                 b_i,
  input  logic [W-1:0]                 w_i,
  input  logic [TAG_W-1:0]             tag_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 a_o,
  output logic [W-1:0]                 b_o,
  output logic [TAG_W-1:0]             tag_o,
  output logic [$clog2(MUL_LAT+4)-1:0] occ,
  output logic                         range_err
);

  localparam int unsigned OCC_W = $clog2(MUL_LAT+4);
  localparam int unsigned LAST  = MUL_LAT - 1;

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W-1:0] dword_t;

  function automatic word_t mod_add(input word_t x, input word_t y);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y};
    if (r >= {1'b0, M}) r = r - {1'b0, M};
    return r[W-1:0];
  endfunction

  function automatic word_t mod_sub(input word_t x, input word_t y);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y};
    if (r[W]) r = r + {1'b0, M};
    return r[W-1:0];
  endfunction

  // Odd x: (x>>1) + (M+1)/2 == (x+M)/2, which stays below M.
  function automatic word_t mod_half(input word_t x);
    return x[0] ? ({1'b0, x[W-1:1]} + M_HALF) : {1'b0, x[W-1:1]};
  endfunction

  function automatic word_t mod_red(input dword_t p);
    return W'(p % {{W{1'b0}}, M});
  endfunction

  logic en, acc, dlv;
  word_t  mul_x, mul_y, dly_in, s_last, p_last, post_a, post_b;
  dword_t mul_full;

  logic vld_p0_q, vld_p0_d;
  logic [1:0] mode_p0_q, mode_p0_d;
  logic [TAG_W-1:0] tag_p0_q, tag_p0_d;
  word_t a_p0_q, a_p0_d, b_p0_q, b_p0_d, w_p0_q, w_p0_d;

  logic             vld_pm_q  [MUL_LAT];
  logic             vld_pm_d  [MUL_LAT];
  logic [1:0]       mode_pm_q [MUL_LAT];
  logic [1:0]       mode_pm_d [MUL_LAT];
  logic [TAG_W-1:0] tag_pm_q  [MUL_LAT];
  logic [TAG_W-1:0] tag_pm_d  [MUL_LAT];
  word_t            dly_pm_q  [MUL_LAT];
  word_t            dly_pm_d  [MUL_LAT];
  dword_t           mul_pm_q  [MUL_LAT];
  dword_t           mul_pm_d  [MUL_LAT];

  logic vld_pp_q, vld_pp_d;
  logic [TAG_W-1:0] tag_pp_q, tag_pp_d;
  word_t a_pp_q, a_pp_d, b_pp_q, b_pp_d;

  logic out_vld_q, out_vld_d;
  logic [TAG_W-1:0] tag_o_q, tag_o_d;
  word_t a_o_q, a_o_d, b_o_q, b_o_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic range_q, range_d;

  always_comb begin
    en  = !out_vld_q || out_ready;
    acc = in_valid && en;
    dlv = out_vld_q && out_ready;

    vld_p0_d = vld_p0_q; mode_p0_d = mode_p0_q; tag_p0_d = tag_p0_q;
    a_p0_d = a_p0_q; b_p0_d = b_p0_q; w_p0_d = w_p0_q;
    vld_pm_d = vld_pm_q; mode_pm_d = mode_pm_q; tag_pm_d = tag_pm_q;
    dly_pm_d = dly_pm_q; mul_pm_d = mul_pm_q;
    vld_pp_d = vld_pp_q; tag_pp_d = tag_pp_q; a_pp_d = a_pp_q; b_pp_d = b_pp_q;
    out_vld_d = out_vld_q; tag_o_d = tag_o_q; a_o_d = a_o_q; b_o_d = b_o_q;
    occ_d = occ_q; range_d = range_q;

    // S0 -> S1: pick multiplier operands and the value that rides the delay line
    mul_x  = w_p0_q;
    mul_y  = b_p0_q;
    dly_in = a_p0_q;
    if (mode_p0_q == 2'b01) mul_y = mod_sub(a_p0_q, b_p0_q);
    if (mode_p0_q[1])       mul_x = a_p0_q;
    if (mode_p0_q != 2'b00) dly_in = mod_add(a_p0_q, b_p0_q);
    mul_full = dword_t'(mul_x) * dword_t'(mul_y);

    // Post-op stage: reduce the product and finish the butterfly
    s_last = dly_pm_q[LAST];
    p_last = mod_red(mul_pm_q[LAST]);
    case (mode_pm_q[LAST])
      2'b00: begin post_a = mod_add(s_last, p_last);  post_b = mod_sub(s_last, p_last);  end
      2'b01: begin post_a = mod_half(s_last);         post_b = mod_half(p_last);         end
      default: begin post_a = s_last;                 post_b = p_last;                   end
    endcase

    if (en) begin
      vld_p0_d = in_valid; mode_p0_d = mode; tag_p0_d = tag_i;
      a_p0_d = a_i; b_p0_d = b_i; w_p0_d = w_i;
      vld_pm_d[0] = vld_p0_q; mode_pm_d[0] = mode_p0_q; tag_pm_d[0] = tag_p0_q;
      dly_pm_d[0] = dly_in;   mul_pm_d[0]  = mul_full;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_pm_d[i] = vld_pm_q[i-1]; mode_pm_d[i] = mode_pm_q[i-1]; tag_pm_d[i] = tag_pm_q[i-1];
        dly_pm_d[i] = dly_pm_q[i-1]; mul_pm_d[i]  = mul_pm_q[i-1];
      end
      vld_pp_d = vld_pm_q[LAST]; tag_pp_d = tag_pm_q[LAST]; a_pp_d = post_a; b_pp_d = post_b;
      out_vld_d = vld_pp_q; tag_o_d = tag_pp_q; a_o_d = a_pp_q; b_o_d = b_pp_q;
    end

    case ({acc, dlv})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // The twiddle is only an operand in the butterfly modes
    if (acc && (a_i >= M || b_i >= M || (!mode[1] && w_i >= M))) range_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      vld_pm_q  <= '{default: 1'b0};
      vld_pp_q  <= 1'b0;
      out_vld_q <= 1'b0;
      tag_o_q   <= '0;
      a_o_q     <= '0;
      b_o_q     <= '0;
      occ_q     <= '0;
      range_q   <= 1'b0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      vld_pm_q  <= vld_pm_d;
      vld_pp_q  <= vld_pp_d;
      out_vld_q <= out_vld_d;
      tag_o_q   <= tag_o_d;
      a_o_q     <= a_o_d;
      b_o_q     <= b_o_d;
      occ_q     <= occ_d;
      range_q   <= range_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_p0_q <= mode_p0_d; tag_p0_q <= tag_p0_d;
    a_p0_q    <= a_p0_d;    b_p0_q   <= b_p0_d;   w_p0_q <= w_p0_d;
    mode_pm_q <= mode_pm_d; tag_pm_q <= tag_pm_d;
    dly_pm_q  <= dly_pm_d;  mul_pm_q <= mul_pm_d;
    tag_pp_q  <= tag_pp_d;  a_pp_q   <= a_pp_d;   b_pp_q <= b_pp_d;
  end

  assign in_ready  = en;
  assign out_valid = out_vld_q;
  assign a_o       = a_o_q;
  assign b_o       = b_o_q;
  assign tag_o     = tag_o_q;
  assign occ       = occ_q;
  assign range_err = range_q;

endmodule
